// File: rtl/buffet_sb_if.sv
// Handshake bundle for buffet_sb: fill, read/shrink, update, response and credit channels.
// Signal suffixes are from the buffet's point of view (slave side).
interface buffet_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned IDX_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] push_data_i;
  logic                  push_valid_i;
  logic                  push_ready_o;

  logic [IDX_WIDTH-1:0]  read_idx_i;
  logic                  read_will_update_i;
  logic                  read_is_shrink_i;
  logic                  read_valid_i;
  logic                  read_ready_o;

  logic [DATA_WIDTH-1:0] read_data_o;
  logic                  read_data_valid_o;
  logic                  read_data_ready_i;

  logic [IDX_WIDTH-1:0]  update_idx_i;
  logic [DATA_WIDTH-1:0] update_data_i;
  logic                  update_valid_i;
  logic                  update_ready_o;

  logic [IDX_WIDTH:0]    credit_o;
  logic                  credit_valid_o;
  logic                  credit_ready_i;

  logic [IDX_WIDTH:0]    occupancy_o;

  modport slave (
    input  push_data_i, push_valid_i,
    output push_ready_o,
    input  read_idx_i, read_will_update_i, read_is_shrink_i, read_valid_i,
    output read_ready_o,
    output read_data_o, read_data_valid_o,
    input  read_data_ready_i,
    input  update_idx_i, update_data_i, update_valid_i,
    output update_ready_o,
    output credit_o, credit_valid_o,
    input  credit_ready_i,
    output occupancy_o
  );

  modport master (
    output push_data_i, push_valid_i,
    input  push_ready_o,
    output read_idx_i, read_will_update_i, read_is_shrink_i, read_valid_i,
    input  read_ready_o,
    input  read_data_o, read_data_valid_o,
    output read_data_ready_i,
    output update_idx_i, update_data_i, update_valid_i,
    input  update_ready_o,
    input  credit_o, credit_valid_o,
    output credit_ready_i,
    input  occupancy_o
  );
endinterface

// File: rtl/buffet_sb.sv
// Single-port circular buffet with per-slot update scoreboard, batched credit return
// and a one-cycle registered read response.
module buffet_sb #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned CREDIT_THRESHOLD = 4
) (
  input  logic      clk,
  input  logic      reset_i,
  buffet_sb_if.slave bus
);
  localparam int unsigned IDX_WIDTH = $clog2(DEPTH);

  typedef logic [IDX_WIDTH-1:0] idx_t;
  typedef logic [IDX_WIDTH:0]   cnt_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t THRESH_C = cnt_t'(CREDIT_THRESHOLD);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  idx_t                  head_q, head_d;
  cnt_t                  occ_q, occ_d;
  cnt_t                  credit_q, credit_d;
  logic [DEPTH-1:0]      pending_q, pending_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  idx_t fill_slot, read_slot, upd_slot;
  cnt_t shrink_sz, shrink_amt;
  logic shrink_blocked;
  logic read_ok, shrink_ok;
  logic fill_fire, read_fire, shrink_fire, upd_fire, credit_fire;

  always_comb begin
    fill_slot = head_q + occ_q[IDX_WIDTH-1:0];
    read_slot = head_q + bus.read_idx_i;
    upd_slot  = head_q + bus.update_idx_i;
    shrink_sz = {1'b0, bus.read_idx_i};

    // A shrink may only retire slots that have no update still outstanding.
    shrink_blocked = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((cnt_t'(i) < shrink_sz) && pending_q[head_q + idx_t'(i)]) begin
        shrink_blocked = 1'b1;
      end
    end

    read_ok   = !bus.read_is_shrink_i
              && ({1'b0, bus.read_idx_i} < occ_q)
              && !pending_q[read_slot]
              && (!rvalid_q || bus.read_data_ready_i);
    shrink_ok = bus.read_is_shrink_i && (shrink_sz <= occ_q) && !shrink_blocked;

    bus.push_ready_o      = (occ_q != DEPTH_C);
    bus.read_ready_o      = read_ok || shrink_ok;
    bus.update_ready_o    = pending_q[upd_slot];
    bus.read_data_o       = rdata_q;
    bus.read_data_valid_o = rvalid_q;
    bus.credit_o          = credit_q;
    bus.credit_valid_o    = (credit_q >= THRESH_C) || ((credit_q != '0) && (occ_q == '0));
    bus.occupancy_o       = occ_q;

    fill_fire   = bus.push_valid_i && bus.push_ready_o;
    read_fire   = bus.read_valid_i && read_ok;
    shrink_fire = bus.read_valid_i && shrink_ok;
    upd_fire    = bus.update_valid_i && bus.update_ready_o;
    credit_fire = bus.credit_valid_o && bus.credit_ready_i;
    shrink_amt  = shrink_fire ? shrink_sz : '0;
  end

  always_comb begin
    head_d    = head_q;
    occ_d     = occ_q;
    credit_d  = credit_q;
    pending_d = pending_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;

    // Fill address uses the pre-shrink head/occ, so both can land in one cycle.
    head_d   = head_q + shrink_amt[IDX_WIDTH-1:0];
    occ_d    = occ_q + cnt_t'(fill_fire) - shrink_amt;
    credit_d = credit_fire ? shrink_amt : credit_q + shrink_amt;

    if (read_fire) begin
      rdata_d  = mem_q[read_slot];
      rvalid_d = 1'b1;
      if (bus.read_will_update_i) begin
        pending_d[read_slot] = 1'b1;
      end
    end else if (bus.read_data_ready_i) begin
      rvalid_d = 1'b0;
    end

    if (upd_fire) begin
      pending_d[upd_slot] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      head_q    <= '0;
      occ_q     <= '0;
      credit_q  <= DEPTH_C;
      pending_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      occ_q     <= occ_d;
      credit_q  <= credit_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_fire) begin
      mem_q[fill_slot] <= bus.push_data_i;
    end
    if (upd_fire) begin
      mem_q[upd_slot] <= bus.update_data_i;
    end
  end
endmodule
